// File: rtl/winograd_output_transform_if.sv
// Stream bundle for the Winograd output transform: product-tile input side, 2x2 result
// output side and a status flag.
interface winograd_output_transform_if #(
  parameter int unsigned PW = 16,
  parameter int unsigned OW = 28
) ();
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [16*PW-1:0] in_tile;
  logic             out_valid;
  logic             out_ready;
  logic [4*OW-1:0]  out_tile;
  logic             busy;

  modport master (
    output in_valid, in_last, in_tile, out_ready,
    input  in_ready, out_valid, out_tile, busy
  );

  modport slave (
    input  in_valid, in_last, in_tile, out_ready,
    output in_ready, out_valid, out_tile, busy
  );
endinterface

// File: rtl/winograd_output_transform.sv
// Winograd F(2x2,3x3) output transform: sums 4x4 product tiles over channels in the
// Winograd domain, then applies Y = A^T M A (rows first, then columns) to emit a 2x2 tile.
module winograd_output_transform #(
  parameter int unsigned PW        = 16,
  parameter int unsigned AW        = 24,
  parameter int unsigned OW        = 28,
  parameter int unsigned OUT_SHIFT = 0
) (
  input logic                        clk,
  input logic                        rstn,
  winograd_output_transform_if.slave bus
);

  localparam logic [1:0] S_ACC = 2'd0;
  localparam logic [1:0] S_ROW = 2'd1;
  localparam logic [1:0] S_COL = 2'd2;
  localparam logic [1:0] S_OUT = 2'd3;

  logic [1:0]           state_q, state_d;
  logic signed [AW-1:0] acc_q [16];
  logic signed [OW-1:0] t0_q [4];
  logic signed [OW-1:0] t1_q [4];
  logic signed [PW-1:0] prod [16];
  logic signed [OW-1:0] y [4];
  logic [4*OW-1:0]      y_packed;
  logic [4*OW-1:0]      out_tile_q;
  logic                 out_valid_q;
  logic                 dirty_q;
  logic                 in_ready;
  logic                 accept;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      prod[i] = bus.in_tile[i*PW +: PW];
    end
  end

  // Gated by rstn so every output reads 0 while reset is held.
  assign in_ready      = rstn && (state_q == S_ACC);
  assign accept        = bus.in_valid && in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_tile  = out_tile_q;
  assign bus.busy      = (state_q != S_ACC) || dirty_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_ACC:   if (accept && bus.in_last) state_d = S_ROW;
      S_ROW:   state_d = S_COL;
      S_COL:   state_d = S_OUT;
      S_OUT:   if (bus.out_ready) state_d = S_ACC;
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // Accumulation wraps modulo 2^AW; cleared as the result is taken in S_COL.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 16; i++) acc_q[i] <= '0;
      dirty_q <= 1'b0;
    end else if (state_q == S_COL) begin
      for (int i = 0; i < 16; i++) acc_q[i] <= '0;
      dirty_q <= 1'b0;
    end else if (accept) begin
      for (int i = 0; i < 16; i++) acc_q[i] <= acc_q[i] + AW'(prod[i]);
      dirty_q <= 1'b1;
    end
  end

  // Row pass: T = A^T M, two rows of four columns.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < 4; c++) begin
        t0_q[c] <= '0;
        t1_q[c] <= '0;
      end
    end else if (state_q == S_ROW) begin
      for (int c = 0; c < 4; c++) begin
        t0_q[c] <= OW'(acc_q[c]) + OW'(acc_q[4+c]) + OW'(acc_q[8+c]);
        t1_q[c] <= OW'(acc_q[4+c]) - OW'(acc_q[8+c]) - OW'(acc_q[12+c]);
      end
    end
  end

  // Column pass: Y = T A, then arithmetic rescale.
  always_comb begin
    y[0] = t0_q[0] + t0_q[1] + t0_q[2];
    y[1] = t0_q[1] - t0_q[2] - t0_q[3];
    y[2] = t1_q[0] + t1_q[1] + t1_q[2];
    y[3] = t1_q[1] - t1_q[2] - t1_q[3];
    y_packed = '0;
    for (int k = 0; k < 4; k++) begin
      y_packed[k*OW +: OW] = y[k] >>> OUT_SHIFT;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_tile_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (state_q == S_COL) begin
      out_tile_q  <= y_packed;
      out_valid_q <= 1'b1;
    end else if (state_q == S_OUT && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_winograd_output_transform.sv
// Bench for winograd_output_transform: table of tiles with hand-computed results, run on
// an OUT_SHIFT=0 and an OUT_SHIFT=1 instance sharing the same input stream.
module tb_winograd_output_transform;
  localparam int unsigned PW = 16;
  localparam int unsigned OW = 28;
  localparam int          NV = 5;

  typedef struct {
    int nbeats;
    int base;
    int step;
    int y00;
    int y01;
    int y10;
    int y11;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  winograd_output_transform_if #(.PW(PW), .OW(OW)) bus0 ();
  winograd_output_transform_if #(.PW(PW), .OW(OW)) bus1 ();

  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.in_last   = bus0.in_last;
  assign bus1.in_tile   = bus0.in_tile;
  assign bus1.out_ready = bus0.out_ready;

  winograd_output_transform #(.PW(PW), .AW(24), .OW(OW), .OUT_SHIFT(0)) dut0 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus0.slave)
  );

  winograd_output_transform #(.PW(PW), .AW(24), .OW(OW), .OUT_SHIFT(1)) dut1 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus1.slave)
  );

  int              n_chk = 0;
  int              n_fail = 0;
  logic [4*OW-1:0] q0[$];
  logic [4*OW-1:0] q1[$];
  vec_t            vecs [NV];

  function automatic void chk(input string name, input logic signed [63:0] act,
                              input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic logic [16*PW-1:0] mk_tile(input int base, input int step);
    logic [16*PW-1:0] t;
    t = '0;
    for (int i = 0; i < 16; i++) t[i*PW +: PW] = PW'(base + step * i);
    return t;
  endfunction

  function automatic logic [4*OW-1:0] pack_y(input vec_t v, input int sh);
    int              y [4];
    logic [4*OW-1:0] p;
    y[0] = v.y00;
    y[1] = v.y01;
    y[2] = v.y10;
    y[3] = v.y11;
    p = '0;
    for (int k = 0; k < 4; k++) p[k*OW +: OW] = OW'(y[k] >>> sh);
    return p;
  endfunction

  function automatic void cmp_tile(input string tag, input logic [4*OW-1:0] act,
                                   input logic [4*OW-1:0] exp);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_y%0d", tag, k), $signed(act[k*OW +: OW]), $signed(exp[k*OW +: OW]));
    end
  endfunction

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send_beat(input logic [16*PW-1:0] t, input logic last);
    int g;
    g = 0;
    bus0.in_valid = 1'b1;
    bus0.in_tile  = t;
    bus0.in_last  = last;
    while (!bus0.in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!bus0.in_ready) chk("in_ready_wait", 0, 1);
    @(negedge clk);
    bus0.in_valid = 1'b0;
  endtask

  task automatic send_tile(input vec_t v);
    logic lst;
    for (int b = 0; b < v.nbeats; b++) begin
      lst = (b == v.nbeats - 1);
      chk("in_ready_acc", bus0.in_ready, 1);
      if (lst) begin
        q0.push_back(pack_y(v, 0));
        q1.push_back(pack_y(v, 1));
      end
      send_beat(mk_tile(v.base, v.step), lst);
      if (!lst) chk("busy_acc", bus0.busy, 1);
    end
  endtask

  task automatic collect();
    int g;
    g = 0;
    while (!bus0.out_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("out_valid_wait", bus0.out_valid, 1);
    chk("out_valid_dut1", bus1.out_valid, 1);
    if (q0.size() == 0 || q1.size() == 0) begin
      chk("scoreboard_has_entry", 0, 1);
    end else begin
      cmp_tile("tile_s0", bus0.out_tile, q0.pop_front());
      cmp_tile("tile_s1", bus1.out_tile, q1.pop_front());
    end
    bus0.out_ready = 1'b1;
    @(negedge clk);
    chk("in_ready_after_hs", bus0.in_ready, 1);
    chk("out_valid_after_hs", bus0.out_valid, 0);
    chk("busy_after_hs", bus0.busy, 0);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_in_ready0"}, bus0.in_ready, 0);
    chk({tag, "_out_valid0"}, bus0.out_valid, 0);
    chk({tag, "_out_tile0"}, bus0.out_tile, 0);
    chk({tag, "_busy0"}, bus0.busy, 0);
    chk({tag, "_in_ready1"}, bus1.in_ready, 0);
    chk({tag, "_out_valid1"}, bus1.out_valid, 0);
    chk({tag, "_out_tile1"}, bus1.out_tile, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1, 1, 0, 9, -3, -3, 1};
    vecs[1] = '{1, 0, 1, 45, -24, -51, 20};
    vecs[2] = '{3, 1, 0, 27, -9, -9, 3};
    vecs[3] = '{2, -2, 0, -36, 12, 12, -4};
    vecs[4] = '{1, 0, -1, -45, 24, 51, -20};

    bus0.in_valid  = 1'b0;
    bus0.in_last   = 1'b0;
    bus0.in_tile   = '0;
    bus0.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check_quiet("reset");
    rstn = 1'b1;
    #1;
    chk("in_ready_post_reset", bus0.in_ready, 1);
    @(negedge clk);

    // Table: each tile must appear exactly two cycles after its last beat is accepted.
    for (int v = 0; v < NV; v++) begin
      send_tile(vecs[v]);
      chk("lat_row_valid", bus0.out_valid, 0);
      chk("lat_row_ready", bus0.in_ready, 0);
      @(negedge clk);
      chk("lat_col_valid", bus0.out_valid, 0);
      chk("lat_col_ready", bus0.in_ready, 0);
      @(negedge clk);
      chk("lat_out_valid", bus0.out_valid, 1);
      collect();
    end

    // Backpressure: result held, input stalled, stray in_valid pulses ignored.
    bus0.out_ready = 1'b0;
    send_tile(vecs[0]);
    repeat (2) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk("bp_out_valid", bus0.out_valid, 1);
      chk("bp_in_ready", bus0.in_ready, 0);
      if (q0.size() > 0) cmp_tile("bp_hold", bus0.out_tile, q0[0]);
      bus0.in_valid = c[0];
      bus0.in_last  = 1'b1;
      bus0.in_tile  = mk_tile(7, 0);
      @(negedge clk);
    end
    bus0.in_valid = 1'b0;
    collect();
    send_tile(vecs[0]);
    collect();

    // Reset midway through a four-beat accumulation.
    send_beat(mk_tile(5, 0), 1'b0);
    send_beat(mk_tile(5, 0), 1'b0);
    chk("busy_partial", bus0.busy, 1);
    rstn = 1'b0;
    #1;
    check_quiet("mid_reset");
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("in_ready_rerelease", bus0.in_ready, 1);
    chk("busy_rerelease", bus0.busy, 0);
    @(negedge clk);
    send_tile(vecs[0]);
    collect();

    chk("scoreboard_drained", q0.size() + q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
